// File: rtl/vector_k_axil_regs.sv
// AXI4-Lite control/status slave for the vector-K search engine: stages a vector word,
// issues commit/start strobes and reports search results with sticky done and an interrupt.
module vector_k_axil_regs #(
  parameter int VEC_W  = 64,
  parameter int ADDR_W = 10,
  parameter int ID_W   = 8,
  parameter int AXI_AW = 8
) (
  input  logic              s_axi_aclk,
  input  logic              s_axi_aresetn,
  input  logic [AXI_AW-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [AXI_AW-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic [ADDR_W-1:0] write_addr,
  output logic [VEC_W-1:0]  write_data,
  output logic              write_en,
  output logic              start_search,
  input  logic              busy,
  input  logic [ID_W-1:0]   winner_id,
  input  logic [31:0]       max_score,
  output logic              irq
);

  localparam int         NW     = VEC_W / 32;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  function automatic logic idx_mapped(input logic [5:0] idx);
    return (idx <= 6'd4) || ((idx >= 6'd8) && (int'(idx) < 8 + NW));
  endfunction

  logic              r_aw_held, r_w_held;
  logic [5:0]        r_aw_idx;
  logic [31:0]       r_w_data;
  logic [3:0]        r_w_strb;
  logic              r_bvalid, r_rvalid;
  logic [1:0]        r_bresp, r_rresp;
  logic [31:0]       r_rdata;
  logic [ADDR_W-1:0] r_addr;
  logic              r_auto_inc, r_irq_en, r_done, r_start_rej, r_busy_q;
  logic              r_start_search, r_write_en, r_inc_pend;
  logic [31:0]       r_data [NW];

  logic        w_aw_hs, w_w_hs, w_ar_hs, w_fire;
  logic        w_ctrl, w_start_ok, w_start_rej, w_commit, w_clr, w_done_set;
  logic [31:0] w_wmask, w_rd_data;
  logic        w_rd_ok;
  logic [5:0]  w_ar_idx;
  logic [15:0] w_win16;
  logic        w_unused;

  // Every channel transfers when valid and ready are both high at a rising edge; a
  // source holds valid and its payload until that edge, and ready never waits on valid.
  assign s_axi_awready = ~r_aw_held & ~r_bvalid;
  assign s_axi_wready  = ~r_w_held & ~r_bvalid;
  assign s_axi_arready = ~r_rvalid;
  assign w_aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_w_hs  = s_axi_wvalid & s_axi_wready;
  assign w_ar_hs = s_axi_arvalid & s_axi_arready;
  assign w_fire  = r_aw_held & r_w_held & ~r_bvalid;

  assign w_wmask = {{8{r_w_strb[3]}}, {8{r_w_strb[2]}}, {8{r_w_strb[1]}}, {8{r_w_strb[0]}}};
  assign w_ctrl      = w_fire & (r_aw_idx == 6'd0) & r_w_strb[0];
  assign w_start_ok  = w_ctrl & r_w_data[0] & ~busy;
  assign w_start_rej = w_ctrl & r_w_data[0] & busy;
  assign w_commit    = w_ctrl & r_w_data[1];
  assign w_clr       = w_ctrl & r_w_data[2];
  assign w_done_set  = r_busy_q & ~busy;

  assign w_ar_idx = s_axi_araddr[7:2];
  assign w_win16  = 16'(winner_id);
  assign w_unused = ^{s_axi_awaddr, s_axi_araddr};

  always_comb begin
    w_rd_data = '0;
    w_rd_ok   = idx_mapped(w_ar_idx);
    case (w_ar_idx)
      6'd1: w_rd_data = {8'd0, w_win16, 5'd0, r_start_rej, r_done, busy};
      6'd2: w_rd_data = max_score;
      6'd3: w_rd_data[ADDR_W-1:0] = r_addr;
      6'd4: w_rd_data[1:0] = {r_irq_en, r_auto_inc};
      default: begin
        for (int i = 0; i < NW; i++)
          if (w_ar_idx == 6'(8 + i)) w_rd_data = r_data[i];
      end
    endcase
  end

  always_comb begin
    write_data = '0;
    for (int i = 0; i < NW; i++) write_data[32*i +: 32] = r_data[i];
  end

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      r_aw_held      <= 1'b0;
      r_w_held       <= 1'b0;
      r_aw_idx       <= '0;
      r_w_data       <= '0;
      r_w_strb       <= '0;
      r_bvalid       <= 1'b0;
      r_bresp        <= OKAY;
      r_rvalid       <= 1'b0;
      r_rresp        <= OKAY;
      r_rdata        <= '0;
      r_addr         <= '0;
      r_auto_inc     <= 1'b0;
      r_irq_en       <= 1'b0;
      r_done         <= 1'b0;
      r_start_rej    <= 1'b0;
      r_busy_q       <= 1'b0;
      r_start_search <= 1'b0;
      r_write_en     <= 1'b0;
      r_inc_pend     <= 1'b0;
      for (int i = 0; i < NW; i++) r_data[i] <= '0;
    end else begin
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_aw_idx  <= s_axi_awaddr[7:2];
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_w_data <= s_axi_wdata;
        r_w_strb <= s_axi_wstrb;
      end
      if (w_fire) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= idx_mapped(r_aw_idx) ? OKAY : SLVERR;
      end else if (r_bvalid && s_axi_bready) begin
        r_bvalid <= 1'b0;
      end

      r_start_search <= w_start_ok;
      r_write_en     <= w_commit;
      r_inc_pend     <= w_commit & r_auto_inc;

      // The strobe cycle always has bvalid high, so no new write can collide with the bump.
      if (w_fire && r_aw_idx == 6'd3)
        r_addr <= (r_addr & ~w_wmask[ADDR_W-1:0]) | (r_w_data[ADDR_W-1:0] & w_wmask[ADDR_W-1:0]);
      else if (r_write_en && r_inc_pend)
        r_addr <= r_addr + 1'b1;

      if (w_fire && r_aw_idx == 6'd4 && r_w_strb[0]) begin
        r_auto_inc <= r_w_data[0];
        r_irq_en   <= r_w_data[1];
      end
      for (int i = 0; i < NW; i++)
        if (w_fire && r_aw_idx == 6'(8 + i))
          r_data[i] <= (r_data[i] & ~w_wmask) | (r_w_data & w_wmask);

      r_busy_q <= busy;
      if (w_done_set) r_done <= 1'b1;
      else if (w_start_ok || w_clr) r_done <= 1'b0;
      if (w_start_rej) r_start_rej <= 1'b1;
      else if (w_clr) r_start_rej <= 1'b0;

      if (w_ar_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_data;
        r_rresp  <= w_rd_ok ? OKAY : SLVERR;
      end else if (r_rvalid && s_axi_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  assign s_axi_bvalid = r_bvalid;
  assign s_axi_bresp  = r_bresp;
  assign s_axi_rvalid = r_rvalid;
  assign s_axi_rresp  = r_rresp;
  assign s_axi_rdata  = r_rdata;
  assign write_addr   = r_addr;
  assign write_en     = r_write_en;
  assign start_search = r_start_search;
  assign irq          = r_done & r_irq_en;

endmodule

// File: tb/tb_vector_k_axil_regs.sv
// Bench for vector_k_axil_regs (VEC_W = 128): directed register-map scenarios plus a
// randomized access stream checked against a register-level model of the block.
module tb_vector_k_axil_regs;
  localparam int         VEC_W  = 128;
  localparam int         NW     = VEC_W / 32;
  localparam int         ADDR_W = 10;
  localparam int         ID_W   = 8;
  localparam int         CW     = ADDR_W + VEC_W;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic              clk, aresetn;
  logic [7:0]        awaddr, araddr;
  logic              awvalid, awready, wvalid, wready, bvalid, bready;
  logic              arvalid, arready, rvalid, rready;
  logic [31:0]       wdata, rdata, max_score;
  logic [3:0]        wstrb;
  logic [1:0]        bresp, rresp;
  logic [ADDR_W-1:0] write_addr;
  logic [VEC_W-1:0]  write_data;
  logic              write_en, start_search, busy, irq;
  logic [ID_W-1:0]   winner_id;

  vector_k_axil_regs #(.VEC_W(VEC_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .AXI_AW(8)) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(aresetn),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .write_addr(write_addr), .write_data(write_data), .write_en(write_en),
    .start_search(start_search), .busy(busy), .winner_id(winner_id),
    .max_score(max_score), .irq(irq)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_tests, n_fail, proto_err, align_err, start_obs, start_exp;
  logic [CW-1:0] exp_q[$];
  logic [CW-1:0] obs_q[$];
  logic prev_b;

  // ---------------- reference model ----------------
  logic [ADDR_W-1:0] m_addr;
  logic [1:0]        m_cfg;
  logic [31:0]       m_data [NW];
  logic              m_done, m_rej;

  task automatic model_reset();
    m_addr = '0; m_cfg = '0; m_done = 1'b0; m_rej = 1'b0;
    for (int i = 0; i < NW; i++) m_data[i] = '0;
  endtask

  function automatic logic [31:0] bytes_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                              input logic [3:0] strb);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
    return res;
  endfunction

  task automatic model_write(input int idx, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] r);
    logic [CW-1:0] v;
    logic [31:0]   tmp;
    r = OKAY;
    if (idx == 0) begin
      if (s[0]) begin
        if (d[0]) begin
          if (busy) m_rej = 1'b1;
          else begin start_exp++; m_done = 1'b0; end
        end
        if (d[1]) begin
          for (int i = 0; i < NW; i++) v[32*i +: 32] = m_data[i];
          v[VEC_W +: ADDR_W] = m_addr;
          exp_q.push_back(v);
          if (m_cfg[0]) m_addr = m_addr + 1'b1;
        end
        if (d[2]) begin m_done = 1'b0; m_rej = 1'b0; end
      end
    end else if (idx == 3) begin
      tmp = bytes_merge(32'(m_addr), d, s);
      m_addr = tmp[ADDR_W-1:0];
    end else if (idx == 4) begin
      tmp = bytes_merge({30'd0, m_cfg}, d, s);
      m_cfg = tmp[1:0];
    end else if (idx >= 8 && idx < 8 + NW) begin
      m_data[idx-8] = bytes_merge(m_data[idx-8], d, s);
    end else if (idx != 1 && idx != 2) begin
      r = SLVERR;
    end
  endtask

  task automatic model_read(input int idx, output logic [31:0] d, output logic [1:0] r);
    r = OKAY;
    d = '0;
    if (idx == 1) d = {8'd0, 16'(winner_id), 5'd0, m_rej, m_done, busy};
    else if (idx == 2) d = max_score;
    else if (idx == 3) d = 32'(m_addr);
    else if (idx == 4) d = {30'd0, m_cfg};
    else if (idx >= 8 && idx < 8 + NW) d = m_data[idx-8];
    else if (idx != 0) r = SLVERR;
  endtask

  // ---------------- strobe monitor ----------------
  always @(negedge clk) begin
    if (aresetn) begin
      if (write_en) begin
        obs_q.push_back({write_addr, write_data});
        if (!(bvalid && !prev_b)) align_err++;
      end
      if (start_search) begin
        start_obs++;
        if (!(bvalid && !prev_b)) align_err++;
      end
    end
    prev_b = bvalid;
  end

  // ---------------- driver tasks ----------------
  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly,
                           output logic [1:0] resp);
    int cyc;
    bit aw_ok, w_ok, b_ok, b_seen;
    logic [1:0] b_hold;
    cyc = 0; aw_ok = 0; w_ok = 0; b_ok = 0; b_seen = 0; resp = 2'bxx; b_hold = 2'b00;
    while (!b_ok && cyc < 100) begin
      awaddr = addr; wdata = data; wstrb = strb;
      awvalid = !aw_ok && cyc >= aw_dly;
      wvalid  = !w_ok && cyc >= w_dly;
      bready  = cyc >= b_dly;
      if ((aw_ok && awready) || (w_ok && wready)) proto_err++;
      if (b_seen && (!bvalid || bresp !== b_hold)) proto_err++;
      if (bvalid && !(aw_ok && w_ok)) proto_err++;
      if (bvalid && !b_seen) begin b_seen = 1; b_hold = bresp; end
      if (awvalid && awready) aw_ok = 1;
      if (wvalid && wready) w_ok = 1;
      if (bvalid && bready) begin b_ok = 1; resp = bresp; end
      @(negedge clk);
      cyc++;
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
    if (!b_ok) begin
      n_tests++; n_fail++;
      $display("FAIL write_timeout: addr %h got no B handshake, required one within 100 cycles", addr);
    end
  endtask

  task automatic axi_read(input logic [7:0] addr, input int r_dly,
                          output logic [31:0] data, output logic [1:0] resp);
    int cyc;
    bit ar_ok, r_ok, r_seen;
    logic [31:0] d_hold;
    logic [1:0]  r_hold;
    cyc = 0; ar_ok = 0; r_ok = 0; r_seen = 0; data = 'x; resp = 2'bxx;
    d_hold = '0; r_hold = '0;
    while (!r_ok && cyc < 100) begin
      araddr = addr;
      arvalid = !ar_ok;
      rready = cyc >= r_dly;
      if (ar_ok && arready) proto_err++;
      if (r_seen && (!rvalid || rdata !== d_hold || rresp !== r_hold)) proto_err++;
      if (rvalid && !r_seen) begin r_seen = 1; d_hold = rdata; r_hold = rresp; end
      if (arvalid && arready) ar_ok = 1;
      if (rvalid && rready) begin r_ok = 1; data = rdata; resp = rresp; end
      @(negedge clk);
      cyc++;
    end
    arvalid = 1'b0; rready = 1'b0;
    if (!r_ok) begin
      n_tests++; n_fail++;
      $display("FAIL read_timeout: addr %h got no R handshake, required one within 100 cycles", addr);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    awaddr = 0; araddr = 0; wdata = 0; wstrb = 0; busy = 0;
    winner_id = 8'h5A; max_score = 32'h0;
    aresetn = 1'b0;
    repeat (3) @(negedge clk);
    aresetn = 1'b1;
    model_reset();
    @(negedge clk);
    n_tests++;
    if ({awready, wready, arready} !== 3'b111) begin
      n_fail++; $display("FAIL reset_ready: got %b required 111", {awready, wready, arready});
    end
    n_tests++;
    if ({bvalid, rvalid} !== 2'b00) begin
      n_fail++; $display("FAIL reset_valid: got %b required 00", {bvalid, rvalid});
    end
    n_tests++;
    if ({bresp, rresp, rdata} !== 36'd0) begin
      n_fail++; $display("FAIL reset_resp: bresp %b rresp %b rdata %h required all 0", bresp, rresp, rdata);
    end
    n_tests++;
    if ({write_en, start_search, irq} !== 3'b000) begin
      n_fail++; $display("FAIL reset_strobes: got %b required 000", {write_en, start_search, irq});
    end
    n_tests++;
    if (write_addr !== '0 || write_data !== '0) begin
      n_fail++; $display("FAIL reset_vec: addr %h data %h required 0", write_addr, write_data);
    end
    // Reset in the middle of a write: a held AW must be dropped.
    awaddr = 8'h0C; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    n_tests++;
    if (awready !== 1'b0) begin
      n_fail++; $display("FAIL aw_held: awready %b required 0", awready);
    end
    aresetn = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({awready, wready, bvalid} !== 3'b110) begin
      n_fail++; $display("FAIL mid_reset: aw/w ready,bvalid %b required 110", {awready, wready, bvalid});
    end
    aresetn = 1'b1;
    @(negedge clk);
    wdata = 32'h1234; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (bvalid !== 1'b0) begin
      n_fail++; $display("FAIL stale_aw: bvalid %b required 0 after reset dropped AW", bvalid);
    end
    aresetn = 1'b0;
    @(negedge clk);
    aresetn = 1'b1;
    model_reset();
    obs_q.delete(); exp_q.delete();
    @(negedge clk);
  endtask

  task automatic test_commit_vec();
    logic [1:0] resp, er;
    logic [CW-1:0] o, e;
    for (int i = 0; i < NW; i++) begin
      axi_write(8'(8'h20 + 4 * i), 32'h11111111 * (i + 1), 4'hF, 0, 0, 0, resp);
      model_write(8 + i, 32'h11111111 * (i + 1), 4'hF, er);
      n_tests++;
      if (resp !== er) begin n_fail++; $display("FAIL data_bresp[%0d]: got %b required %b", i, resp, er); end
    end
    axi_write(8'h0C, 32'h005, 4'hF, 0, 0, 0, resp);
    model_write(3, 32'h005, 4'hF, er);
    axi_write(8'h00, 32'h2, 4'hF, 0, 0, 0, resp);
    model_write(0, 32'h2, 4'hF, er);
    n_tests++;
    if (resp !== er) begin n_fail++; $display("FAIL ctrl_bresp: got %b required %b", resp, er); end
    // Random partial-strobe updates followed by commits.
    for (int k = 0; k < 6; k++) begin
      int idx;
      logic [31:0] d;
      logic [3:0] s;
      idx = (k % 2 == 0) ? 8 + int'($urandom_range(0, NW - 1)) : 3;
      d = $urandom; s = 4'($urandom_range(0, 15));
      axi_write(8'(idx * 4), d, s, $urandom_range(0, 2), $urandom_range(0, 2), 0, resp);
      model_write(idx, d, s, er);
      axi_write(8'h00, 32'h2, 4'h1, 0, 0, $urandom_range(0, 3), resp);
      model_write(0, 32'h2, 4'h1, er);
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL commit_count: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL commit_vec: got %h required %h", o, e); end
    end
    obs_q.delete(); exp_q.delete();
    n_tests++;
    if (align_err != 0) begin n_fail++; $display("FAIL strobe_align: %0d misaligned strobes, required 0", align_err); end
  endtask

  task automatic test_auto_inc();
    logic [1:0] resp, er;
    logic [31:0] d, ed;
    logic [CW-1:0] o, e;
    axi_write(8'h10, 32'h1, 4'hF, 0, 0, 0, resp); model_write(4, 32'h1, 4'hF, er);
    axi_write(8'h0C, 32'h3FF, 4'hF, 0, 0, 0, resp); model_write(3, 32'h3FF, 4'hF, er);
    repeat (2) begin
      axi_write(8'h00, 32'h2, 4'hF, 0, 0, 0, resp); model_write(0, 32'h2, 4'hF, er);
    end
    repeat (2) @(negedge clk);
    n_tests++;
    if (obs_q.size() != 2) begin n_fail++; $display("FAIL inc_count: got %0d required 2", obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_tests++;
      if (o[CW-1:VEC_W] !== e[CW-1:VEC_W]) begin
        n_fail++; $display("FAIL inc_addr: got %h required %h", o[CW-1:VEC_W], e[CW-1:VEC_W]);
      end
    end
    obs_q.delete(); exp_q.delete();
    axi_read(8'h0C, 0, d, resp); model_read(3, ed, er);
    n_tests++;
    if (d !== ed || resp !== er) begin n_fail++; $display("FAIL inc_readback: got %h/%b required %h/%b", d, resp, ed, er); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] resp, er;
    logic [31:0] d, ed;
    logic [CW-1:0] o, e;
    int perr0;
    perr0 = proto_err;
    // W three cycles ahead of AW, bready low for four cycles of bvalid.
    axi_write(8'h00, 32'h2, 4'hF, 3, 0, 9, resp);
    model_write(0, 32'h2, 4'hF, er);
    axi_write(8'h24, 32'hCAFE0001, 4'hF, 0, 0, 0, resp); model_write(9, 32'hCAFE0001, 4'hF, er);
    axi_write(8'h24, 32'hBEEF0002, 4'h3, 0, 0, 0, resp); model_write(9, 32'hBEEF0002, 4'h3, er);
    repeat (2) @(negedge clk);
    n_tests++;
    if (proto_err != perr0) begin n_fail++; $display("FAIL b2b_protocol: %0d violations required 0", proto_err - perr0); end
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL b2b_commits: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL b2b_vec: got %h required %h", o, e); end
    end
    obs_q.delete(); exp_q.delete();
    axi_read(8'h24, 0, d, resp); model_read(9, ed, er);
    n_tests++;
    if (d !== ed) begin n_fail++; $display("FAIL b2b_data: got %h required %h", d, ed); end
  endtask

  task automatic test_start();
    logic [1:0] resp, er;
    logic [31:0] d, ed;
    winner_id = 8'($urandom);
    busy = 1'b1;
    repeat (2) @(negedge clk);
    axi_write(8'h00, 32'h1, 4'hF, 0, 0, 0, resp); model_write(0, 32'h1, 4'hF, er);
    repeat (2) @(negedge clk);
    n_tests++;
    if (start_obs != start_exp) begin n_fail++; $display("FAIL start_rejected: pulses %0d required %0d", start_obs, start_exp); end
    axi_read(8'h04, 0, d, resp); model_read(1, ed, er);
    n_tests++;
    if (d !== ed) begin n_fail++; $display("FAIL status_rej: got %h required %h", d, ed); end
    busy = 1'b0; m_done = 1'b1;
    repeat (2) @(negedge clk);
    axi_write(8'h00, 32'h1, 4'hF, 0, 0, 0, resp); model_write(0, 32'h1, 4'hF, er);
    repeat (2) @(negedge clk);
    n_tests++;
    if (start_obs != start_exp) begin n_fail++; $display("FAIL start_accepted: pulses %0d required %0d", start_obs, start_exp); end
    axi_read(8'h04, 0, d, resp); model_read(1, ed, er);
    n_tests++;
    if (d !== ed) begin n_fail++; $display("FAIL status_started: got %h required %h", d, ed); end
    axi_write(8'h10, 32'h2, 4'hF, 0, 0, 0, resp); model_write(4, 32'h2, 4'hF, er);
    busy = 1'b1;
    repeat (3) @(negedge clk);
    busy = 1'b0; m_done = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (irq !== (m_done & m_cfg[1])) begin n_fail++; $display("FAIL irq_set: got %b required %b", irq, m_done & m_cfg[1]); end
    axi_read(8'h04, 0, d, resp); model_read(1, ed, er);
    n_tests++;
    if (d !== ed) begin n_fail++; $display("FAIL status_done: got %h required %h", d, ed); end
    axi_write(8'h00, 32'h4, 4'hF, 0, 0, 0, resp); model_write(0, 32'h4, 4'hF, er);
    @(negedge clk);
    n_tests++;
    if (irq !== (m_done & m_cfg[1])) begin n_fail++; $display("FAIL irq_clear: got %b required %b", irq, m_done & m_cfg[1]); end
    axi_read(8'h04, 0, d, resp); model_read(1, ed, er);
    n_tests++;
    if (d !== ed) begin n_fail++; $display("FAIL status_clr: got %h required %h", d, ed); end
  endtask

  task automatic test_read();
    logic [1:0] resp, er;
    logic [31:0] d, ed;
    int perr0;
    int ids[7] = '{1, 3, 4, 8, 9, 10, 11};
    perr0 = proto_err;
    max_score = 32'hDEADBEEF;
    axi_read(8'h08, 3, d, resp);
    n_tests++;
    if (d !== 32'hDEADBEEF || resp !== OKAY || proto_err != perr0) begin
      n_fail++; $display("FAIL score_read: got %h/%b viol %0d required deadbeef/00 viol 0", d, resp, proto_err - perr0);
    end
    axi_read(8'h7C, 0, d, resp); model_read(31, ed, er);
    n_tests++;
    if (d !== ed || resp !== er) begin n_fail++; $display("FAIL unmapped_read: got %h/%b required %h/%b", d, resp, ed, er); end
    axi_write(8'h7C, 32'hFFFFFFFF, 4'hF, 0, 0, 0, resp); model_write(31, 32'hFFFFFFFF, 4'hF, er);
    n_tests++;
    if (resp !== er) begin n_fail++; $display("FAIL unmapped_write: got %b required %b", resp, er); end
    foreach (ids[k]) begin
      axi_read(8'(ids[k] * 4), 0, d, resp); model_read(ids[k], ed, er);
      n_tests++;
      if (d !== ed || resp !== er) begin
        n_fail++; $display("FAIL regfile[%0d]: got %h/%b required %h/%b", ids[k], d, resp, ed, er);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] resp, er;
    logic [31:0] d, ed;
    logic [CW-1:0] o, e;
    int perr0, idx;
    perr0 = proto_err;
    winner_id = 8'($urandom); max_score = $urandom;
    for (int n = 0; n < 60; n++) begin
      idx = $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 0) begin
        logic [31:0] wd;
        logic [3:0] ws;
        wd = $urandom; ws = 4'($urandom_range(0, 15));
        axi_write(8'(idx * 4), wd, ws, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), resp);
        model_write(idx, wd, ws, er);
        n_tests++;
        if (resp !== er) begin n_fail++; $display("FAIL rand_bresp idx %0d: got %b required %b", idx, resp, er); end
      end else begin
        axi_read(8'(idx * 4), $urandom_range(0, 3), d, resp);
        model_read(idx, ed, er);
        n_tests++;
        if (d !== ed || resp !== er) begin
          n_fail++; $display("FAIL rand_read idx %0d: got %h/%b required %h/%b", idx, d, resp, ed, er);
        end
      end
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rand_commits: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL rand_vec: got %h required %h", o, e); end
    end
    n_tests++;
    if (start_obs != start_exp) begin n_fail++; $display("FAIL rand_starts: got %0d required %0d", start_obs, start_exp); end
    n_tests++;
    if (proto_err != perr0 || align_err != 0) begin
      n_fail++; $display("FAIL rand_protocol: viol %0d misaligned %0d required 0/0", proto_err - perr0, align_err);
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0; proto_err = 0; align_err = 0; start_obs = 0; start_exp = 0;
    prev_b = 1'b0;
    test_reset();
    test_commit_vec();
    test_auto_inc();
    test_back_to_back();
    test_start();
    test_read();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
